// File: rtl/row_capture_scheduler.sv
// Decimating row/pixel capture scheduler feeding a 2-entry ping-pong line buffer.
// Bresenham accumulators pick OUT_ROWS rows per frame and OUT_COLS pixels per row.
module row_capture_scheduler #(
   parameter int MAX_WIDTH  = 1920,
   parameter int MAX_HEIGHT = 1080,
   parameter int OUT_COLS   = 16,
   parameter int OUT_ROWS   = 8,
   localparam int W_W   = $clog2(MAX_WIDTH),
   localparam int H_W   = $clog2(MAX_HEIGHT),
   localparam int COL_W = $clog2(OUT_COLS),
   localparam int ROW_W = $clog2(OUT_ROWS)
) (
   input  logic             I_rgb_clk,
   input  logic             I_rst,
   input  logic             I_rgb_de,
   input  logic             I_new_row,
   input  logic             I_new_frame,
   input  logic [W_W-1:0]   I_image_width,
   input  logic [H_W-1:0]   I_image_height,
   input  logic             I_width_valid,
   input  logic             I_height_valid,
   output logic             O_wr_en,
   output logic             O_wr_buf,
   output logic [COL_W-1:0] O_wr_addr,
   output logic             O_line_valid,
   output logic             O_line_buf,
   output logic [ROW_W-1:0] O_line_idx,
   input  logic             I_line_ack,
   output logic             O_frame_done,
   output logic             O_overflow
);

   // Accumulators overshoot the geometry when it is smaller than the output grid.
   localparam int ACC_H = H_W + ROW_W + 1;
   localparam int ACC_W = W_W + COL_W + 1;
   localparam logic [ACC_H-1:0] ROW_STEP = ACC_H'(OUT_ROWS);
   localparam logic [ACC_W-1:0] COL_STEP = ACC_W'(OUT_COLS);
   localparam logic [ROW_W:0]   ROWS_MAX = (ROW_W + 1)'(OUT_ROWS);
   localparam logic [COL_W:0]   COLS_MAX = (COL_W + 1)'(OUT_COLS);
   localparam logic [ROW_W:0]   SEL_ONE  = {{ROW_W{1'b0}}, 1'b1};
   localparam logic [COL_W:0]   COL_ONE  = {{COL_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, SCAN, CAPTURE} state_t;

   state_t                    state_q, state_d;
   logic [ACC_H-1:0]          row_acc_q, row_acc_d;
   logic [ACC_W-1:0]          col_acc_q, col_acc_d;
   logic [ROW_W:0]            sel_cnt_q, sel_cnt_d;
   logic [COL_W:0]            col_cnt_q, col_cnt_d;
   logic [ROW_W-1:0]          line_idx_q, line_idx_d;
   logic                      seen_de_q, seen_de_d;
   logic [1:0]                full_q, full_d;
   logic                      wr_ptr_q, wr_ptr_d;
   logic                      rd_ptr_q, rd_ptr_d;
   logic [1:0][ROW_W-1:0]     idx_q, idx_d;
   logic                      wr_en_q, wr_en_d;
   logic                      wr_buf_q, wr_buf_d;
   logic [COL_W-1:0]          wr_addr_q, wr_addr_d;
   logic                      frame_done_q, frame_done_d;
   logic                      overflow_q, overflow_d;

   logic             geo_ok;
   logic [ACC_H-1:0] row_nxt, height_ext;
   logic [ACC_W-1:0] col_nxt, width_ext;
   logic             row_hit, col_hit, row_done;
   logic [ROW_W:0]   sel_inc;

   always_comb begin
      geo_ok     = I_width_valid & I_height_valid & (|I_image_width) & (|I_image_height);
      height_ext = ACC_H'(I_image_height);
      width_ext  = ACC_W'(I_image_width);
      row_nxt    = row_acc_q + ROW_STEP;
      row_hit    = row_nxt >= height_ext;
      col_nxt    = col_acc_q + COL_STEP;
      col_hit    = (col_nxt >= width_ext) && (col_cnt_q < COLS_MAX);
      sel_inc    = sel_cnt_q + SEL_ONE;
   end

   always_comb begin
      state_d      = state_q;
      row_acc_d    = row_acc_q;
      col_acc_d    = col_acc_q;
      sel_cnt_d    = sel_cnt_q;
      col_cnt_d    = col_cnt_q;
      line_idx_d   = line_idx_q;
      seen_de_d    = seen_de_q;
      full_d       = full_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      idx_d        = idx_q;
      wr_en_d      = 1'b0;
      wr_buf_d     = wr_buf_q;
      wr_addr_d    = wr_addr_q;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      row_done     = 1'b0;

      // Consumer side never conflicts with completion: the write target is always empty.
      if (I_line_ack && full_q[rd_ptr_q]) begin
         full_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = ~rd_ptr_q;
      end

      if (!geo_ok) begin
         state_d = IDLE;
      end else if (I_new_frame && (state_q == SCAN || state_q == CAPTURE)) begin
         frame_done_d = 1'b1;
         row_acc_d    = '0;
         sel_cnt_d    = '0;
         state_d      = SCAN;
      end else begin
         case (state_q)
            IDLE: state_d = WAIT_FRAME;
            WAIT_FRAME: begin
               if (I_new_frame) begin
                  row_acc_d = '0;
                  sel_cnt_d = '0;
                  state_d   = SCAN;
               end
            end
            SCAN: begin
               if (I_new_row) begin
                  row_acc_d = row_hit ? row_nxt - height_ext : row_nxt;
                  if (row_hit && !full_q[wr_ptr_q]) begin
                     col_acc_d  = '0;
                     col_cnt_d  = '0;
                     seen_de_d  = 1'b0;
                     line_idx_d = sel_cnt_q[ROW_W-1:0];
                     state_d    = CAPTURE;
                  end else if (row_hit) begin
                     overflow_d = 1'b1;
                     row_done   = 1'b1;
                  end
               end
            end
            CAPTURE: begin
               if (I_rgb_de) begin
                  seen_de_d = 1'b1;
                  col_acc_d = col_hit ? col_nxt - width_ext : col_nxt;
                  if (col_hit) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = col_cnt_q[COL_W-1:0];
                     wr_buf_d  = wr_ptr_q;
                     col_cnt_d = col_cnt_q + COL_ONE;
                  end
               end else if (seen_de_q) begin
                  full_d[wr_ptr_q] = 1'b1;
                  idx_d[wr_ptr_q]  = line_idx_q;
                  wr_ptr_d         = ~wr_ptr_q;
                  row_done         = 1'b1;
                  state_d          = SCAN;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (row_done) begin
         sel_cnt_d = sel_inc;
         if (sel_inc == ROWS_MAX) begin
            frame_done_d = 1'b1;
            state_d      = WAIT_FRAME;
         end
      end
   end

   always_ff @(posedge I_rgb_clk) begin
      if (I_rst) begin
         state_q      <= IDLE;
         row_acc_q    <= '0;
         col_acc_q    <= '0;
         sel_cnt_q    <= '0;
         col_cnt_q    <= '0;
         line_idx_q   <= '0;
         seen_de_q    <= 1'b0;
         full_q       <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         idx_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_buf_q     <= 1'b0;
         wr_addr_q    <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_acc_q    <= row_acc_d;
         col_acc_q    <= col_acc_d;
         sel_cnt_q    <= sel_cnt_d;
         col_cnt_q    <= col_cnt_d;
         line_idx_q   <= line_idx_d;
         seen_de_q    <= seen_de_d;
         full_q       <= full_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         idx_q        <= idx_d;
         wr_en_q      <= wr_en_d;
         wr_buf_q     <= wr_buf_d;
         wr_addr_q    <= wr_addr_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign O_wr_en      = wr_en_q;
   assign O_wr_buf     = wr_buf_q;
   assign O_wr_addr    = wr_addr_q;
   assign O_line_valid = full_q[rd_ptr_q];
   assign O_line_buf   = rd_ptr_q;
   assign O_line_idx   = idx_q[rd_ptr_q];
   assign O_frame_done = frame_done_q;
   assign O_overflow   = overflow_q;

endmodule

// File: tb/tb_row_capture_scheduler.sv
// Bench for row_capture_scheduler: directed scenarios plus randomized frames,
// compared every cycle against a queue-based behavioural model.
module tb_row_capture_scheduler;

   localparam int COLS = 16;
   localparam int ROWS = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        de = 1'b0, nr = 1'b0, nf = 1'b0;
   logic [10:0] w = 11'd16, h = 11'd16;
   logic        wv = 1'b1, hv = 1'b1, ack = 1'b0;
   logic        o_wr_en, o_wr_buf, o_line_valid, o_line_buf, o_frame_done, o_overflow;
   logic [3:0]  o_wr_addr;
   logic [2:0]  o_line_idx;

   row_capture_scheduler #(.MAX_WIDTH(1920), .MAX_HEIGHT(1080), .OUT_COLS(COLS), .OUT_ROWS(ROWS)) dut (
      .I_rgb_clk(clk), .I_rst(rst), .I_rgb_de(de), .I_new_row(nr), .I_new_frame(nf),
      .I_image_width(w), .I_image_height(h), .I_width_valid(wv), .I_height_valid(hv),
      .O_wr_en(o_wr_en), .O_wr_buf(o_wr_buf), .O_wr_addr(o_wr_addr),
      .O_line_valid(o_line_valid), .O_line_buf(o_line_buf), .O_line_idx(o_line_idx),
      .I_line_ack(ack), .O_frame_done(o_frame_done), .O_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;
   int ack_mode = 0;
   int cur_pix = -1, pix_s = -1;
   int row_wr_cnt = 0, n_wr = 0, n_fd = 0;
   bit chk_en = 1'b0, chk_pix2 = 1'b0;
   int ack_log[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {int b; int idx;} line_t;
   line_t mq[$];
   bit m_armed = 0, m_run = 0, m_cap = 0, m_seen = 0, m_ovf = 0;
   bit m_wr = 0, m_fd = 0;
   int m_racc = 0, m_sel = 0, m_cacc = 0, m_ccnt = 0, m_idx = 0;
   int m_wbuf = 0, m_waddr = 0, m_wb = 0;

   task m_end_row();
      m_sel++;
      if (m_sel == ROWS) begin
         m_fd  = 1;
         m_run = 0;
         m_cap = 0;
      end
   endtask

   always @(posedge clk) begin
      bit geo, full_now;
      m_wr = 0;
      m_fd = 0;
      if (rst) begin
         m_armed = 0; m_run = 0; m_cap = 0; m_ovf = 0;
         m_wbuf = 0; m_racc = 0; m_sel = 0; m_waddr = 0; m_wb = 0;
         mq.delete();
      end else begin
         geo = wv && hv && (w != 0) && (h != 0);
         full_now = (mq.size() == 2);
         if (ack && mq.size() > 0) void'(mq.pop_front());
         if (!geo) begin
            m_armed = 0; m_run = 0; m_cap = 0;
         end else if (!m_armed) begin
            m_armed = 1;
         end else if (!m_run) begin
            if (nf) begin m_run = 1; m_racc = 0; m_sel = 0; m_cap = 0; end
         end else if (nf) begin
            m_fd = 1; m_racc = 0; m_sel = 0; m_cap = 0;
         end else if (!m_cap) begin
            if (nr) begin
               m_racc += ROWS;
               if (m_racc >= int'(h)) begin
                  m_racc -= int'(h);
                  if (!full_now) begin
                     m_cap = 1; m_cacc = 0; m_ccnt = 0; m_seen = 0; m_idx = m_sel;
                  end else begin
                     m_ovf = 1;
                     m_end_row();
                  end
               end
            end
         end else if (de) begin
            m_seen = 1;
            m_cacc += COLS;
            if (m_cacc >= int'(w) && m_ccnt < COLS) begin
               m_cacc -= int'(w);
               m_wr = 1; m_waddr = m_ccnt; m_wb = m_wbuf;
               m_ccnt++;
            end
         end else if (m_seen) begin
            mq.push_back('{b: m_wbuf, idx: m_idx});
            m_wbuf ^= 1;
            m_cap = 0;
            m_end_row();
         end
      end
   end

   always @(posedge clk) pix_s <= cur_pix;

   // ---------------- per-cycle compare + monitors ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("wr_en", o_wr_en, m_wr);
         if (m_wr) begin
            check("wr_addr", o_wr_addr, m_waddr);
            check("wr_buf", o_wr_buf, m_wb);
         end
         check("line_valid", o_line_valid, mq.size() > 0);
         if (mq.size() > 0) begin
            check("line_buf", o_line_buf, mq[0].b);
            check("line_idx", o_line_idx, mq[0].idx);
         end else begin
            check("line_buf_empty", o_line_buf, m_wbuf);
         end
         check("frame_done", o_frame_done, m_fd);
         check("overflow", o_overflow, m_ovf);
         if (chk_pix2 && o_wr_en === 1'b1) check("pix_lag", pix_s, 2 * row_wr_cnt + 1);
      end
      if (o_wr_en === 1'b1) begin n_wr++; row_wr_cnt++; end
      if (o_frame_done === 1'b1) n_fd++;
      if (!rst && ack && o_line_valid === 1'b1) ack_log.push_back(int'(o_line_idx));
   end

   // ---------------- stimulus ----------------
   task automatic tick(input bit force_ack = 1'b0);
      case (ack_mode)
         0: ack = 1'b0;
         1: ack = 1'b1;
         default: ack = 1'($urandom_range(0, 1));
      endcase
      if (force_ack) ack = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic new_frame();
      nf = 1'b1; tick(); nf = 1'b0; tick();
   endtask

   task automatic drive_row(input int npix, input int gap, input int abort_at = -1, input bit ack_end = 1'b0);
      row_wr_cnt = 0;
      nr = 1'b1; tick(); nr = 1'b0;
      repeat (gap) tick();
      for (int p = 0; p < npix; p++) begin
         de = 1'b1; cur_pix = p;
         if (p == abort_at) nf = 1'b1;
         tick();
         nf = 1'b0;
      end
      de = 1'b0; cur_pix = -1;
      tick(ack_end);
      tick();
   endtask

   task automatic run_frame(input int nrows, input int npix, input int gap);
      new_frame();
      for (int r = 0; r < nrows; r++) drive_row(npix, gap);
   endtask

   initial begin
      int wr0, fd0;
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_wr_en", o_wr_en, 0);
      check("rst_line_valid", o_line_valid, 0);
      check("rst_overflow", o_overflow, 0);
      check("rst_frame_done", o_frame_done, 0);
      idle(2);

      // 16x16 source, consumer always ready
      ack_mode = 1; w = 16; h = 16;
      ack_log.delete(); wr0 = n_wr; fd0 = n_fd;
      run_frame(16, 16, 1);
      idle(3);
      check("t1_writes", n_wr - wr0, 128);
      check("t1_frame_done", n_fd - fd0, 1);
      check("t1_lines", ack_log.size(), 8);
      for (int i = 0; i < ack_log.size(); i++) check("t1_idx_order", ack_log[i], i);
      check("t1_overflow", o_overflow, 0);

      // 32x8 source: every row, odd pixels
      w = 32; h = 8;
      ack_log.delete(); wr0 = n_wr; fd0 = n_fd;
      chk_pix2 = 1'b1;
      run_frame(8, 32, 2);
      chk_pix2 = 1'b0;
      idle(2);
      check("t2_writes", n_wr - wr0, 128);
      check("t2_frame_done", n_fd - fd0, 1);
      check("t2_lines", ack_log.size(), 8);

      // no consumer: queue fills, later rows dropped
      ack_mode = 0; w = 16; h = 16; fd0 = n_fd;
      run_frame(16, 16, 1);
      check("t3_valid", o_line_valid, 1);
      check("t3_buf0", o_line_buf, 0);
      check("t3_idx0", o_line_idx, 0);
      check("t3_overflow", o_overflow, 1);
      check("t3_frame_done", n_fd - fd0, 1);
      tick(1'b1);
      check("t3_buf1", o_line_buf, 1);
      check("t3_idx1", o_line_idx, 1);
      check("t3_overflow_sticky", o_overflow, 1);
      tick(1'b1);
      check("t3_drained", o_line_valid, 0);

      // new frame mid-capture
      fd0 = n_fd;
      new_frame();
      drive_row(16, 1);
      drive_row(16, 1, 5);
      check("t4_no_full", o_line_valid, 0);
      check("t4_frame_done", n_fd - fd0, 1);
      drive_row(16, 1);
      drive_row(16, 1);
      check("t4_valid", o_line_valid, 1);
      check("t4_idx_restart", o_line_idx, 0);
      check("t4_buf", o_line_buf, 0);
      tick(1'b1);

      // geometry drop during scan
      ack_mode = 1;
      new_frame();
      drive_row(16, 1);
      hv = 1'b0; wr0 = n_wr;
      drive_row(16, 1);
      drive_row(16, 1);
      check("t5_no_writes", n_wr - wr0, 0);
      hv = 1'b1;
      idle(2);
      ack_log.delete(); wr0 = n_wr;
      run_frame(16, 16, 1);
      idle(2);
      check("t5_writes", n_wr - wr0, 128);
      check("t5_lines", ack_log.size(), 8);

      // reset with both buffers full, then completion + ack together
      ack_mode = 0;
      run_frame(16, 16, 1);
      check("t6_full_before", o_line_valid, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("t6_valid", o_line_valid, 0);
      check("t6_overflow", o_overflow, 0);
      check("t6_wr_en", o_wr_en, 0);
      check("t6_wr_buf", o_wr_buf, 0);
      check("t6_wr_addr", o_wr_addr, 0);
      check("t6_line_buf", o_line_buf, 0);
      check("t6_line_idx", o_line_idx, 0);
      check("t6_frame_done", o_frame_done, 0);
      idle(2);
      ack_log.delete();
      new_frame();
      drive_row(16, 1);
      drive_row(16, 1);
      drive_row(16, 1);
      drive_row(16, 1, -1, 1'b1);
      check("t6_valid_after", o_line_valid, 1);
      check("t6_buf_after", o_line_buf, 1);
      check("t6_idx_after", o_line_idx, 1);
      check("t6_acked", ack_log.size(), 1);
      if (ack_log.size() > 0) check("t6_acked_idx", ack_log[0], 0);
      tick(1'b1);

      // randomized frames
      ack_mode = 2;
      for (int f = 0; f < 25; f++) begin
         int nrows;
         w = 11'($urandom_range(1, 40));
         h = 11'($urandom_range(1, 20));
         nrows = $urandom_range(1, int'(h) + 3);
         new_frame();
         for (int r = 0; r < nrows; r++) begin
            if ($urandom_range(0, 29) == 0) wv = 1'b0;
            if ($urandom_range(0, 59) == 0) begin
               rst = 1'b1; tick(); rst = 1'b0;
            end
            if ($urandom_range(0, 19) == 0)
               drive_row(int'(w), $urandom_range(0, 2), $urandom_range(0, int'(w) - 1));
            else
               drive_row(int'(w), $urandom_range(0, 2));
            if (!wv) begin wv = 1'b1; idle(2); end
         end
         idle($urandom_range(1, 4));
      end
      idle(5);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_chk, n_err);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/row_capture_scheduler.md
Name: row_capture_scheduler

Overview:
- Sequences capture of decimated video rows from the DVI receive path into a 2-entry ping-pong line buffer for the LED-matrix transmit side.
- Consumes the row/frame strobes and the measured geometry from the sync manager.
- Selects OUT_ROWS source rows per frame and OUT_COLS pixels per selected row using accumulator (Bresenham) decimation.
- Issues line-buffer write strobes and hands completed lines to the consumer through a valid/ack handshake.

Parameters:
MAX_WIDTH, 1920, maximum source width; sets the width of I_image_width (W_W = $clog2(MAX_WIDTH))
MAX_HEIGHT, 1080, maximum source height; sets the width of I_image_height (H_W = $clog2(MAX_HEIGHT))
OUT_COLS, 16, pixels captured per selected row (LED matrix columns)
OUT_ROWS, 8, rows captured per frame (LED matrix rows)

Ports:
I_rgb_clk  in  1  pixel clock; only clock
I_rst  in  1  synchronous reset, active-high
I_rgb_de  in  1  data enable from the DVI receiver
I_new_row  in  1  one-cycle pulse, at least 1 cycle before the first DE of each row
I_new_frame  in  1  one-cycle pulse before the first I_new_row of a frame
I_image_width  in  W_W  measured active width
I_image_height  in  H_W  measured active height
I_width_valid  in  1  width measurement stable
I_height_valid  in  1  height measurement stable
O_wr_en  out  1  line-buffer write strobe
O_wr_buf  out  1  target buffer (0/1)
O_wr_addr  out  $clog2(OUT_COLS)  column address
O_line_valid  out  1  a completed line is available
O_line_buf  out  1  buffer holding the oldest completed line
O_line_idx  out  $clog2(OUT_ROWS)  matrix row index of that line
I_line_ack  in  1  consumer releases the presented line
O_frame_done  out  1  one-cycle pulse after the last row of a frame is resolved
O_overflow  out  1  sticky: a selected row was dropped because both buffers were full

Behaviour:
- Reset: all outputs 0; state IDLE; full[1:0] = 0; wr_ptr = rd_ptr = 0; accumulators and counters = 0.
- Geometry valid (geo_ok) = I_width_valid & I_height_valid & width != 0 & height != 0.
  - geo_ok low in any state -> next cycle IDLE; any in-progress capture is abandoned (buffer not marked full).
  - full flags and the output queue are unaffected by geo_ok.
- IDLE -> WAIT_FRAME when geo_ok.
- WAIT_FRAME -> SCAN on I_new_frame; clear row_acc, sel_cnt.
- SCAN, on I_new_row:
  - row_nxt = row_acc + OUT_ROWS.
  - Row is selected iff row_nxt >= height; then row_acc <= row_nxt - height, else row_acc <= row_nxt.
  - Selected and full[wr_ptr] == 0 -> CAPTURE; clear col_acc, col_cnt; latch line_idx = sel_cnt.
  - Selected and full[wr_ptr] == 1 -> row dropped; O_overflow <= 1; sel_cnt++.
- CAPTURE, each cycle with I_rgb_de = 1:
  - col_nxt = col_acc + OUT_COLS.
  - Pixel is selected iff col_nxt >= width and col_cnt < OUT_COLS; then col_acc <= col_nxt - width, else col_acc <= col_nxt.
  - Selected pixel: O_wr_en = 1 one cycle later (registered), O_wr_addr = col_cnt, O_wr_buf = wr_ptr; col_cnt++.
  - The datapath delays RGB by one register to align with O_wr_en.
- CAPTURE, first cycle with DE = 0 after at least one DE cycle:
  - full[wr_ptr] <= 1; store line_idx for that buffer; wr_ptr toggles; sel_cnt++; return to SCAN.
  - Unwritten addresses (width < OUT_COLS) keep stale data.
- When sel_cnt reaches OUT_ROWS, or on I_new_frame while in SCAN/CAPTURE:
  - O_frame_done pulses once.
  - I_new_frame restarts the frame: counters clear, any in-progress capture is aborted without marking its buffer full, then SCAN.
  - Otherwise the block waits in WAIT_FRAME.
- Height < OUT_ROWS: every row is selected and fewer than OUT_ROWS lines are produced; O_frame_done fires on the next I_new_frame.
- Output queue (2-entry FIFO):
  - O_line_valid = full[rd_ptr]; O_line_buf = rd_ptr; O_line_idx = stored index of rd_ptr.
  - I_line_ack while valid: full[rd_ptr] <= 0, rd_ptr toggles. Ack while not valid is ignored.
  - Completion and ack in the same cycle on different buffers both take effect.
- I_rst mid-operation: everything returns to reset values on the next edge; queued lines are discarded.

Test Plan:
1. Width=16, height=16, always ack -> rows 1,3,5,…,15 captured with idx 0..7; 16 writes per row, addr 0..15; O_frame_done one pulse; O_overflow = 0.
2. Width=32, height=8 -> every row captured; pixels 1,3,…,31 written at addr 0..15; O_wr_en lags DE by 1 cycle.
3. Height=16, no ack -> two lines queued (idx 0 in buf0, idx 1 in buf1); third selected row dropped; O_overflow = 1 and stays 1; after one ack, O_line_buf = 1, O_line_idx = 1.
4. I_new_frame asserted mid-CAPTURE at pixel 5 -> no full flag set; O_frame_done pulses; next row selection restarts at idx 0.
5. I_height_valid deasserted during SCAN -> IDLE next cycle, O_wr_en stays 0; revalidate plus I_new_frame -> normal capture resumes.
6. I_rst asserted with both buffers full -> next cycle O_line_valid = 0, O_overflow = 0, all outputs 0; completion and ack in the same cycle verified with no lost line.
